// File: rtl/plugboard_pair_table.sv
`default_nettype none
// ============================================================================
// Module      : plugboard_pair_table
// Description : Programmable Enigma plugboard with a shared partner table
//               serving a front and a rear one-hot encode channel.
//               Optional macro PLUG_UNDO_EN adds an undo port and pair stack.
// Revision    : 1.0 - initial release
// ============================================================================
module plugboard_pair_table #(
  parameter int  LETTERS   = 26,
  parameter int  MAX_PAIRS = 10,
  localparam int CW        = $clog2(MAX_PAIRS + 1)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               prog_valid,
  input  logic [LETTERS-1:0] prog_letter,
  output logic               prog_err,
  output logic               prog_pending,
  output logic [CW-1:0]      pair_count,
  output logic               table_full,
  input  logic               f_valid,
  input  logic [LETTERS-1:0] f_in,
  output logic [LETTERS-1:0] f_out,
  output logic               f_out_valid,
  input  logic               r_valid,
  input  logic [LETTERS-1:0] r_in,
  output logic [LETTERS-1:0] r_out,
  output logic               r_out_valid
`ifdef PLUG_UNDO_EN
  ,input logic               undo
`endif
);

  localparam int IW = $clog2(LETTERS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_partner [LETTERS];
  logic [IW-1:0]       r_held;
  logic [CW-1:0]       r_pair_count;
  logic                r_prog_err;
  logic [LETTERS-1:0]  w_plugged;
  logic                w_prog_oh;
  logic [IW-1:0]       w_prog_idx;
  logic                w_prog_plugged;
  logic                w_full;
  logic [LETTERS-1:0]  w_f_map;
  logic [LETTERS-1:0]  w_r_map;

`ifdef PLUG_UNDO_EN
  logic [IW-1:0]       r_stack_a [MAX_PAIRS];
  logic [IW-1:0]       r_stack_b [MAX_PAIRS];
  logic [CW-1:0]       w_top;
  assign w_top = r_pair_count - CW'(1);
`endif

  function automatic logic f_is_onehot(input logic [LETTERS-1:0] v);
    return (v != '0) && ((v & (v - LETTERS'(1))) == '0);
  endfunction

  function automatic logic [IW-1:0] f_idx(input logic [LETTERS-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < LETTERS; i++) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic [LETTERS-1:0] f_dec(input logic [IW-1:0] idx);
    logic [LETTERS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // A letter is plugged whenever its partner entry points somewhere else
  for (genvar gi = 0; gi < LETTERS; gi++) begin : g_plugged
    assign w_plugged[gi] = (r_partner[gi] != IW'(gi));
  end

  assign w_prog_oh      = f_is_onehot(prog_letter);
  assign w_prog_idx     = f_idx(prog_letter);
  assign w_prog_plugged = |(prog_letter & w_plugged);
  assign w_full         = (r_pair_count == CW'(MAX_PAIRS));

  assign prog_err     = r_prog_err;
  assign prog_pending = (r_state == S_WAIT);
  assign pair_count   = r_pair_count;
  assign table_full   = w_full;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_held       <= '0;
      r_pair_count <= '0;
      r_prog_err   <= 1'b0;
      for (int i = 0; i < LETTERS; i++) r_partner[i] <= IW'(i);
`ifdef PLUG_UNDO_EN
      for (int i = 0; i < MAX_PAIRS; i++) begin
        r_stack_a[i] <= '0;
        r_stack_b[i] <= '0;
      end
`endif
    end else begin
      r_prog_err <= 1'b0;
`ifdef PLUG_UNDO_EN
      // Undo takes priority; a coincident prog_valid is silently dropped
      if (undo) begin
        if (r_state == S_WAIT) begin
          r_state <= S_IDLE;
        end else if (r_pair_count != '0) begin
          r_partner[r_stack_a[w_top]] <= r_stack_a[w_top];
          r_partner[r_stack_b[w_top]] <= r_stack_b[w_top];
          r_pair_count                <= w_top;
        end else begin
          r_prog_err <= 1'b1;
        end
      end else
`endif
      if (prog_valid) begin
        case (r_state)
          S_IDLE: begin
            if (!w_prog_oh || w_prog_plugged || w_full) begin
              r_prog_err <= 1'b1;
            end else begin
              r_held  <= w_prog_idx;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!w_prog_oh || (w_prog_idx == r_held) || w_prog_plugged) begin
              r_prog_err <= 1'b1;
            end else begin
              r_partner[r_held]     <= w_prog_idx;
              r_partner[w_prog_idx] <= r_held;
`ifdef PLUG_UNDO_EN
              r_stack_a[r_pair_count] <= r_held;
              r_stack_b[r_pair_count] <= w_prog_idx;
`endif
              r_pair_count <= r_pair_count + CW'(1);
              r_state      <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Lookups read the current table, so a same-edge program update is not seen
  always_comb begin
    w_f_map = f_in;
    w_r_map = r_in;
    if (f_is_onehot(f_in)) w_f_map = f_dec(r_partner[f_idx(f_in)]);
    if (f_is_onehot(r_in)) w_r_map = f_dec(r_partner[f_idx(r_in)]);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      f_out       <= '0;
      f_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      f_out_valid <= f_valid;
      r_out_valid <= r_valid;
      if (f_valid) f_out <= w_f_map;
      if (r_valid) r_out <= w_r_map;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plugboard_pair_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_plugboard_pair_table
// Description : Directed self-checking bench for plugboard_pair_table
//               (undo steps are built only when PLUG_UNDO_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plugboard_pair_table;

  localparam int L  = 26;
  localparam int CW = $clog2(10 + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog_valid;
  logic [L-1:0]  prog_letter;
  logic          prog_err;
  logic          prog_pending;
  logic [CW-1:0] pair_count;
  logic          table_full;
  logic          f_valid;
  logic [L-1:0]  f_in;
  logic [L-1:0]  f_out;
  logic          f_out_valid;
  logic          r_valid;
  logic [L-1:0]  r_in;
  logic [L-1:0]  r_out;
  logic          r_out_valid;
`ifdef PLUG_UNDO_EN
  logic          undo;
`endif

  int checks = 0;
  int errors = 0;

  plugboard_pair_table #(.LETTERS(L), .MAX_PAIRS(10)) dut (
    .CLOCK_50    (clk),
    .reset       (rst_n),
    .prog_valid  (prog_valid),
    .prog_letter (prog_letter),
    .prog_err    (prog_err),
    .prog_pending(prog_pending),
    .pair_count  (pair_count),
    .table_full  (table_full),
    .f_valid     (f_valid),
    .f_in        (f_in),
    .f_out       (f_out),
    .f_out_valid (f_out_valid),
    .r_valid     (r_valid),
    .r_in        (r_in),
    .r_out       (r_out),
    .r_out_valid (r_out_valid)
`ifdef PLUG_UNDO_EN
    ,.undo       (undo)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [L-1:0] oh(input int i);
    return L'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [L-1:0] v);
    prog_valid  = 1'b1;
    prog_letter = v;
    tick();
    prog_valid  = 1'b0;
    prog_letter = '0;
  endtask

  task automatic enc_f(input logic [L-1:0] v);
    f_valid = 1'b1;
    f_in    = v;
    tick();
    f_valid = 1'b0;
  endtask

  task automatic enc_r(input logic [L-1:0] v);
    r_valid = 1'b1;
    r_in    = v;
    tick();
    r_valid = 1'b0;
  endtask

`ifdef PLUG_UNDO_EN
  task automatic do_undo();
    undo = 1'b1;
    tick();
    undo = 1'b0;
  endtask
`endif

  initial begin
    int lo [8] = '{3, 5, 7, 9, 11, 13, 15, 18};
    int hi [8] = '{4, 6, 8, 10, 12, 14, 17, 19};

    rst_n = 1'b0; prog_valid = 1'b0; prog_letter = '0;
    f_valid = 1'b0; f_in = '0; r_valid = 1'b0; r_in = '0;
`ifdef PLUG_UNDO_EN
    undo = 1'b0;
`endif
    tick(); tick();
    chk("rst_count", 32'(pair_count), 0);
    chk("rst_pending", 32'(prog_pending), 0);
    chk("rst_err", 32'(prog_err), 0);
    chk("rst_full", 32'(table_full), 0);
    chk("rst_fvalid", 32'(f_out_valid), 0);
    chk("rst_fout", 32'(f_out), 0);
    rst_n = 1'b1;
    tick();

    // Identity mapping after reset, then hold with valid low
    enc_f(oh(0));
    chk("id_valid", 32'(f_out_valid), 1);
    chk("id_fout", 32'(f_out), 32'(oh(0)));
    tick();
    chk("hold_valid", 32'(f_out_valid), 0);
    chk("hold_fout", 32'(f_out), 32'(oh(0)));

    // Non-one-hot passes through on both channels
    f_valid = 1'b1; f_in = 26'h3; r_valid = 1'b1; r_in = '0;
    tick();
    f_valid = 1'b0; r_valid = 1'b0;
    chk("mh_fout", 32'(f_out), 32'h3);
    chk("zero_rout", 32'(r_out), 0);
    chk("zero_rvalid", 32'(r_out_valid), 1);

    // Rejections while holding A
    prog(oh(0));
    chk("a1_pending", 32'(prog_pending), 1);
    chk("a1_err", 32'(prog_err), 0);
    prog(oh(0));
    chk("aa_err", 32'(prog_err), 1);
    chk("aa_pending", 32'(prog_pending), 1);
    prog(26'h3);
    chk("mh_err", 32'(prog_err), 1);
    chk("mh_pending", 32'(prog_pending), 1);
    chk("mh_count", 32'(pair_count), 0);
    prog(oh(16));
    chk("aq_err", 32'(prog_err), 0);
    chk("aq_pending", 32'(prog_pending), 0);
    chk("aq_count", 32'(pair_count), 1);

    // Both channels on one cycle
    f_valid = 1'b1; f_in = oh(0); r_valid = 1'b1; r_in = oh(16);
    tick();
    f_valid = 1'b0; r_valid = 1'b0;
    chk("f_a2q", 32'(f_out), 32'(oh(16)));
    chk("r_q2a", 32'(r_out), 32'(oh(0)));

    prog(oh(0));
    chk("plug_idle_err", 32'(prog_err), 1);
    chk("plug_idle_pend", 32'(prog_pending), 0);
    prog(oh(1));
    prog(oh(16));
    chk("plug_wait_err", 32'(prog_err), 1);
    chk("plug_wait_pend", 32'(prog_pending), 1);

    // Complete B/C on the same edge as encoding B
    prog_valid = 1'b1; prog_letter = oh(2); f_valid = 1'b1; f_in = oh(1);
    tick();
    prog_valid = 1'b0; f_valid = 1'b0;
    chk("same_edge_fout", 32'(f_out), 32'(oh(1)));
    chk("bc_count", 32'(pair_count), 2);
    enc_f(oh(1));
    chk("f_b2c", 32'(f_out), 32'(oh(2)));
    enc_r(oh(2));
    chk("r_c2b", 32'(r_out), 32'(oh(1)));

    for (int k = 0; k < 8; k++) begin
      prog(oh(lo[k]));
      prog(oh(hi[k]));
      chk($sformatf("fill_count_%0d", k), 32'(pair_count), 32'(k + 3));
      if (k == 6) chk("nine_not_full", 32'(table_full), 0);
    end
    chk("full", 32'(table_full), 1);
    prog(oh(20));
    chk("full_err", 32'(prog_err), 1);
    chk("full_pending", 32'(prog_pending), 0);
    chk("full_count", 32'(pair_count), 10);
    enc_f(oh(19));
    chk("f_t2s", 32'(f_out), 32'(oh(18)));
    enc_r(oh(25));
    chk("r_z_id", 32'(r_out), 32'(oh(25)));

    // Asynchronous reset mid-encode and mid-pair
    f_valid = 1'b1; f_in = oh(19);
    tick();
    f_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_fout", 32'(f_out), 0);
    chk("arst_fvalid", 32'(f_out_valid), 0);
    chk("arst_count", 32'(pair_count), 0);
    chk("arst_full", 32'(table_full), 0);
    rst_n = 1'b1;
    tick();
    prog(oh(0));
    chk("mid_pend", 32'(prog_pending), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_pend", 32'(prog_pending), 0);
    rst_n = 1'b1;
    tick();
    enc_f(oh(0));
    chk("post_rst_id", 32'(f_out), 32'(oh(0)));

`ifdef PLUG_UNDO_EN
    prog(oh(0)); prog(oh(16));
    prog(oh(1)); prog(oh(2));
    chk("u_count2", 32'(pair_count), 2);
    do_undo();
    chk("u_count1", 32'(pair_count), 1);
    enc_f(oh(1));
    chk("u_b_id", 32'(f_out), 32'(oh(1)));
    enc_f(oh(0));
    chk("u_a2q", 32'(f_out), 32'(oh(16)));
    do_undo();
    chk("u_count0", 32'(pair_count), 0);
    chk("u_err0", 32'(prog_err), 0);
    do_undo();
    chk("u_empty_err", 32'(prog_err), 1);
    prog(oh(3));
    do_undo();
    chk("u_wait_pend", 32'(prog_pending), 0);
    chk("u_wait_count", 32'(pair_count), 0);
    chk("u_wait_err", 32'(prog_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plugboard_pair_table.md
Name: plugboard_pair_table

Overview:
Parametrised, programmable Enigma plugboard that holds up to MAX_PAIRS letter swaps in a registered partner table. Letter pairs are loaded one letter per strobe by a small FSM, with validation. One shared table serves two independent one-hot encode channels: front (keyboard → rotors) and rear (rotors → display). Sits between the keyboard decoder, the rotor/reflector stage and the GUI; it replaces the single fixed ten-pair combinational plugboard.

Parameters:
LETTERS, 26, alphabet size; width of every one-hot letter bus.
MAX_PAIRS, 10, maximum stored swap pairs; must satisfy 1 <= MAX_PAIRS <= LETTERS/2.
CW, $clog2(MAX_PAIRS+1), width of pair_count (derived, not overridden).

Ports:
CLOCK_50  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-low reset.
prog_valid  in  1  one-cycle strobe: prog_letter is valid.
prog_letter  in  LETTERS  one-hot letter being programmed.
prog_err  out  1  one-cycle pulse: last prog_letter rejected.
prog_pending  out  1  first letter of a pair is held, awaiting the partner.
pair_count  out  CW  number of stored pairs.
table_full  out  1  pair_count == MAX_PAIRS.
f_valid  in  1  front channel input strobe.
f_in  in  LETTERS  front one-hot letter.
f_out  out  LETTERS  front mapped letter.
f_out_valid  out  1  f_out is valid this cycle.
r_valid  in  1  rear channel input strobe.
r_in  in  LETTERS  rear one-hot letter.
r_out  out  LETTERS  rear mapped letter.
r_out_valid  out  1  r_out is valid this cycle.
undo  in  1  (PLUG_UNDO_EN only) one-cycle strobe: remove the most recent pair.

Behaviour:
- Reset: table cleared, so every letter maps to itself. pair_count=0, FSM in IDLE, first-letter register=0, all outputs 0.
- Table: per-letter partner register, plus a pair stack of MAX_PAIRS entries (letter A index, letter B index) in program order.
- FSM IDLE, on prog_valid:
  - Reject (prog_err=1 next cycle, stay in IDLE) if the letter is not exactly one-hot, is already plugged, or table_full=1.
  - Otherwise latch the letter and go to WAIT_SECOND.
- FSM WAIT_SECOND (prog_pending=1), on prog_valid:
  - Reject (prog_err, stay in WAIT_SECOND) if the letter is not one-hot, equals the held letter, or is already plugged.
  - Otherwise write both partner entries, push the pair onto the stack, increment pair_count, return to IDLE.
  - All updates are visible on the clock edge after the accepting strobe.
- Encode channels are independent and may fire on the same cycle:
  - Registered, 1-cycle latency: f_out_valid = f_valid delayed 1 cycle; f_out = partner(f_in) sampled at the f_valid edge. Rear channel identical.
  - Input not exactly one-hot (zero or multi-hot): passes through unchanged, valid still asserted.
  - Output without a new valid holds its last value; valid is low.
- Simultaneous encode and accepting program edge: encode uses the pre-update table. The new pair applies from the next cycle.
- Pair completion with pair_count == MAX_PAIRS-1: stores the pair, table_full rises. Further first letters are rejected.
- Symmetry invariant: partner(partner(x)) == x for all x at all times.
- Reset asserted mid-pair or mid-encode: immediate clear. No partial pair survives.

Optional Feature:
PLUG_UNDO_EN:
- Defined:
  - undo port exists.
  - undo in IDLE with pair_count>0 pops the top stack pair, restores both letters to self-map and decrements pair_count (next edge).
  - undo in WAIT_SECOND discards the held letter and returns to IDLE, table unchanged.
  - undo with pair_count=0 in IDLE raises prog_err.
  - undo coincident with prog_valid: undo wins, and prog_valid is ignored without error.
- Undefined: no undo port, no stack logic beyond what is needed for pair_count; pairs are removed only by reset.

Test Plan:
- Reset, then f_valid with f_in=A (26'h1) → next cycle f_out_valid=1, f_out=26'h1 (identity).
- Program A then Q (26'h10000) → pair_count=1. Then front encode A → f_out=26'h10000, and rear encode Q on the same cycle → r_out=26'h1.
- Program A then A, then program multi-hot 26'h3 → prog_err pulses on each; prog_pending remains 1 after the first A; pair_count stays 0.
- With MAX_PAIRS=10, program 10 disjoint pairs → table_full=1. Then the 11th first letter → prog_err, prog_pending stays 0.
- Complete pair B/C on the same edge as f_in=B → f_out=B. A second encode of B on the next cycle → f_out=C.
- PLUG_UNDO_EN: program A/Q then B/C, pulse undo → pair_count=1, B→B, A→Q; undo twice more → pair_count=0, then prog_err.
